// File: rtl/add_exec_unit.sv
// add_exec_unit: serialised execute/write-back stage for register_file.
// One R-type instruction is processed at a time: IDLE -> READ -> EXEC -> WB.
// ADD and SUB wrap modulo 2^DATA_W. Writes to r0 are suppressed.
// Optional feature macro: OVERFLOW_TRAP_EN. When it is defined, the block gets an
// ovf output, and ADD/SUB signed overflow cancels the write and raises ovf in WB.
module add_exec_unit #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    output logic [ADDR_W-1:0] readAdr1,
    output logic [ADDR_W-1:0] readAdr2,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    output logic [ADDR_W-1:0] writeAdr,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable,
`ifdef OVERFLOW_TRAP_EN
    output logic              ovf,
`endif
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    state_t                    state;
    state_t                    nextState;
    logic                      accept;
    logic [1:0]                opReg;
    logic [ADDR_W-1:0]         rdReg;
    logic signed [DATA_W-1:0]  opA;
    logic signed [DATA_W-1:0]  opB;
    logic signed [DATA_W-1:0]  aluResult;
    logic                      ovfNow;

`ifdef OVERFLOW_TRAP_EN
    // Two's-complement overflow: operands that agree in sign (ADD) or differ in
    // sign (SUB) produce a result whose sign differs from the first operand.
    function automatic logic signedOvf(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b,
                                       input logic signed [DATA_W-1:0] r,
                                       input logic                     isSub);
        logic signsAgree;
        signsAgree = (a[DATA_W-1] == b[DATA_W-1]);
        return (isSub ? !signsAgree : signsAgree) && (r[DATA_W-1] != a[DATA_W-1]);
    endfunction
`endif

    assign accept = in_valid && in_ready;

    // State register; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Next-state decode; only IDLE waits, every other state advances each cycle.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = READ;
            end
            READ:    nextState = EXEC;
            EXEC:    nextState = WB;
            WB:      nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ALU on the latched operands; the carry/borrow out is simply dropped.
    always_comb begin
        aluResult = '0;
        ovfNow    = 1'b0;
        case (opReg)
            OP_ADD:  aluResult = opA + opB;
            OP_SUB:  aluResult = opA - opB;
            OP_AND:  aluResult = opA & opB;
            default: aluResult = opA | opB;
        endcase
`ifdef OVERFLOW_TRAP_EN
        if (opReg == OP_ADD || opReg == OP_SUB)
            ovfNow = signedOvf(opA, opB, aluResult, opReg == OP_SUB);
`endif
    end

    // Instruction and operand capture: fields at accept, register data in READ.
    // The read addresses are registered so they hold outside READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opReg    <= '0;
            rdReg    <= '0;
            readAdr1 <= '0;
            readAdr2 <= '0;
            opA      <= '0;
            opB      <= '0;
        end else begin
            if (accept) begin
                opReg    <= in_op;
                rdReg    <= in_rd;
                readAdr1 <= in_rs1;
                readAdr2 <= in_rs2;
            end
            if (state == READ) begin
                opA <= readData1;
                opB <= readData2;
            end
        end
    end

    // Write-back outputs are registered on the EXEC->WB edge so they are valid
    // for exactly the WB cycle; writeData doubles as the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeAdr    <= '0;
            writeData   <= '0;
            writeEnable <= 1'b0;
            done        <= 1'b0;
`ifdef OVERFLOW_TRAP_EN
            ovf         <= 1'b0;
`endif
        end else begin
            writeEnable <= (state == EXEC) && (rdReg != '0) && !ovfNow;
            done        <= (state == EXEC);
`ifdef OVERFLOW_TRAP_EN
            ovf         <= (state == EXEC) && ovfNow;
`endif
            if (state == EXEC) begin
                writeAdr  <= rdReg;
                writeData <= aluResult;
            end
        end
    end

endmodule

// File: tb/tb_add_exec_unit.sv
// Bench for add_exec_unit: behavioural register file, scoreboard of expected
// write-backs pushed at issue time and popped when done pulses.
module tb_add_exec_unit;

    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic [AW-1:0] readAdr1, readAdr2, writeAdr;
    logic [DW-1:0] readData1, readData2, writeData;
    logic          writeEnable, done;
`ifdef OVERFLOW_TRAP_EN
    logic          ovf;
`endif

    always #5 clk = ~clk;

    add_exec_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .readAdr1(readAdr1), .readAdr2(readAdr2),
        .readData1(readData1), .readData2(readData2),
        .writeAdr(writeAdr), .writeData(writeData), .writeEnable(writeEnable),
`ifdef OVERFLOW_TRAP_EN
        .ovf(ovf),
`endif
        .done(done)
    );

    // Register file environment: combinational read, write on rising edge.
    logic [DW-1:0] regs [64];
    logic          clrAll, ldEn;
    logic [AW-1:0] ldAdr;
    logic [DW-1:0] ldVal;

    assign readData1 = regs[readAdr1];
    assign readData2 = regs[readAdr2];

    always @(posedge clk) begin
        if (clrAll) begin
            for (int i = 0; i < 64; i++) regs[i] <= '0;
        end else if (ldEn) begin
            regs[ldAdr] <= ldVal;
        end else if (writeEnable) begin
            regs[writeAdr] <= writeData;
        end
    end

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
        logic          we;
        logic          ov;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model [64];
    int            nChecks = 0;
    int            nPass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nChecks++;
        assert (got === exp) nPass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: result from extended-width arithmetic, overflow from the extra bit.
    function automatic exp_t predict(input logic [1:0] op, input int rd,
                                     input logic [DW-1:0] a, input logic [DW-1:0] b);
        exp_t        e;
        logic [DW:0] wide;
        e.ov = 1'b0;
        case (op)
            2'b00: begin wide = {a[DW-1], a} + {b[DW-1], b}; e.data = wide[DW-1:0]; e.ov = wide[DW] ^ wide[DW-1]; end
            2'b01: begin wide = {a[DW-1], a} - {b[DW-1], b}; e.data = wide[DW-1:0]; e.ov = wide[DW] ^ wide[DW-1]; end
            2'b10: e.data = a & b;
            default: e.data = a | b;
        endcase
`ifndef OVERFLOW_TRAP_EN
        e.ov = 1'b0;
`endif
        e.adr = AW'(rd);
        e.we  = (rd != 0) && !e.ov;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest expected write-back.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wb_adr", 64'(writeAdr), 64'(e.adr));
                    check("wb_data", writeData, e.data);
                    check("wb_we", 64'(writeEnable), 64'(e.we));
`ifdef OVERFLOW_TRAP_EN
                    check("wb_ovf", 64'(ovf), 64'(e.ov));
`endif
                end
            end else if (writeEnable) begin
                check("we_without_done", 64'd1, 64'd0);
            end
        end
    end

    task automatic preload(input int adr, input logic [DW-1:0] val);
        @(negedge clk);
        ldEn  = 1'b1;
        ldAdr = AW'(adr);
        ldVal = val;
        model[adr] = val;
        @(posedge clk);
        #1 ldEn = 1'b0;
    endtask

    task automatic expect_instr(input logic [1:0] op, input int rd, input int rs1, input int rs2);
        exp_t e;
        e = predict(op, rd, model[rs1], model[rs2]);
        sb.push_back(e);
        if (e.we) model[rd] = e.data;
    endtask

    // Present an instruction and hold it until accepted; returns 1ns after the accept edge.
    task automatic issue(input logic [1:0] op, input int rd, input int rs1, input int rs2, input bit track);
        int t;
        if (track) expect_instr(op, rd, rs1, rs2);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = AW'(rd);
        in_rs1   = AW'(rs1);
        in_rs2   = AW'(rs2);
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait until all expected write-backs are seen, then let the last write land.
    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            #1 t++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  low;
        bit  seen;
        rst_n    = 1'b0;
        clrAll   = 1'b1;
        ldEn     = 1'b0;
        ldAdr    = '0;
        ldVal    = '0;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_rs1   = '0;
        in_rs2   = '0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        clrAll = 1'b0;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(writeEnable), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_readAdr1", 64'(readAdr1), 64'd0);
        check("rst_readAdr2", 64'(readAdr2), 64'd0);
        check("rst_writeAdr", 64'(writeAdr), 64'd0);
        check("rst_writeData", writeData, 64'd0);
`ifdef OVERFLOW_TRAP_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;

        preload(1, 64'd3);
        preload(2, 64'd5);

        // ADD r3 = r1 + r2 with cycle-exact latency checks
        issue(2'b00, 3, 1, 2, 1'b1);
        @(negedge clk);
        check("lat_readAdr1", 64'(readAdr1), 64'd1);
        check("lat_readAdr2", 64'(readAdr2), 64'd2);
        check("lat_busy", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("lat_no_early_we", 64'(writeEnable), 64'd0);
        @(negedge clk);
        check("lat_we", 64'(writeEnable), 64'd1);
        check("lat_writeAdr", 64'(writeAdr), 64'd3);
        check("lat_writeData", writeData, 64'd8);
        drain();

        // SUB / AND / OR / write to r0
        issue(2'b01, 4, 1, 2, 1'b1);
        issue(2'b10, 10, 1, 2, 1'b1);
        issue(2'b11, 11, 1, 2, 1'b1);
        issue(2'b00, 0, 1, 2, 1'b1);
        drain();
        check("r0_zero", regs[0], 64'd0);
        check("r4_sub", regs[4], 64'hFFFF_FFFF_FFFF_FFFE);
        check("r10_and", regs[10], 64'd1);
        check("r11_or", regs[11], 64'd7);

        // Back-to-back with in_valid held high: second sees the first write
        expect_instr(2'b00, 3, 1, 2);
        expect_instr(2'b00, 5, 3, 3);
        @(negedge clk);
        check("b2b_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = 2'b00; in_rd = 6'd3; in_rs1 = 6'd1; in_rs2 = 6'd2;
        @(posedge clk);
        #1 in_rd = 6'd5; in_rs1 = 6'd3; in_rs2 = 6'd3;
        low = 0;
        while (low < 10) begin
            @(negedge clk);
            if (in_ready) break;
            low++;
        end
        check("b2b_gap", 64'(low), 64'd3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        check("r5_b2b", regs[5], 64'd16);

        // Reset pulsed during EXEC: instruction dropped, no write
        issue(2'b00, 7, 1, 2, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_we", 64'(writeEnable), 64'd0);
        check("midrst_readAdr1", 64'(readAdr1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | writeEnable | done;
        end
        check("midrst_no_wb", 64'(seen), 64'd0);
        check("midrst_r7", regs[7], 64'd0);

        // Normal operation resumes after reset
        issue(2'b11, 8, 1, 2, 1'b1);
        drain();
        check("r8_or", regs[8], 64'd7);

        // Signed-overflow boundaries on ADD and SUB
        preload(1, 64'h7FFF_FFFF_FFFF_FFFF);
        preload(9, 64'h8000_0000_0000_0000);
        preload(13, 64'd1);
        issue(2'b00, 6, 1, 1, 1'b1);
        issue(2'b01, 12, 9, 13, 1'b1);
        issue(2'b00, 14, 1, 9, 1'b1);
        drain();
        check("r6_ovf_add", regs[6], model[6]);
        check("r12_ovf_sub", regs[12], model[12]);
        check("r14_no_ovf", regs[14], 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef OVERFLOW_TRAP_EN
        check("r6_kept", regs[6], 64'd0);
`else
        check("r6_wrapped", regs[6], 64'hFFFF_FFFF_FFFF_FFFE);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
